// File: rtl/jam_cost_table.sv
// Cost-table responder for the JAM engine: loads 64 costs, then serves lookups and checks the result.
// Zero-cycle lookup; the load port accepts one entry per cycle via LD_READY, and the engine is held in reset until the table is full.
module jam_cost_table #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LD_VALID,
   input  logic [6:0]  LD_DATA,
   output logic        LD_READY,
   output logic        JAM_RST,
   input  logic [2:0]  W,
   input  logic [2:0]  J,
   output logic [6:0]  Cost,
   input  logic        Valid,
   input  logic [9:0]  MinCost,
   input  logic [3:0]  MatchCount,
   input  logic [9:0]  EXP_MIN,
   input  logic [3:0]  EXP_CNT,
   output logic        DONE,
   output logic        PASS,
   output logic        TIMEOUT,
   output logic [19:0] CYCLES
);

   localparam logic [19:0] LP_TIMEOUT = 20'(TIMEOUT_CYC);
   localparam logic [19:0] LP_CYC_MAX = 20'hFFFFF;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SERVE, ST_CHECK} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_xfer;
   logic        w_timeout;
   logic [5:0]  r_idx;
   logic [6:0]  r_table [64];
   logic        r_ld_ready;
   logic        r_jam_rst;
   logic        r_done;
   logic        r_pass;
   logic        r_timeout;
   logic [19:0] r_cycles;

   always_comb begin
      w_next    = r_state;
      w_xfer    = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         ST_IDLE:  w_next = ST_LOAD;
         ST_LOAD: begin
            w_xfer = r_ld_ready && LD_VALID;
            if (w_xfer && (r_idx == 6'd63)) w_next = ST_SERVE;
         end
         ST_SERVE: begin
            // Valid has priority over the watchdog in the same cycle.
            if (Valid) begin
               w_next = ST_CHECK;
            end else if (r_cycles == LP_TIMEOUT) begin
               w_timeout = 1'b1;
               w_next    = ST_CHECK;
            end
         end
         default:  w_next = ST_CHECK;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_ld_ready <= 1'b0;
         r_jam_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_timeout  <= 1'b0;
         r_cycles   <= '0;
         for (int i = 0; i < 64; i++) r_table[i] <= '0;
      end else begin
         r_state    <= w_next;
         // Ready waits one cycle in LOAD so it rises on the second edge after reset release.
         r_ld_ready <= (r_state == ST_LOAD) && (w_next == ST_LOAD);
         r_jam_rst  <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
         if (w_xfer) begin
            r_table[r_idx] <= LD_DATA;
            r_idx          <= r_idx + 6'd1;
         end
         if ((r_state == ST_SERVE) && (w_next == ST_SERVE) && (r_cycles != LP_CYC_MAX))
            r_cycles <= r_cycles + 20'd1;
         if ((r_state == ST_SERVE) && Valid) begin
            r_done <= 1'b1;
            r_pass <= (MinCost == EXP_MIN) && (MatchCount == EXP_CNT);
         end
         if (w_timeout) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
         end
      end
   end

   assign Cost     = r_table[{W, J}];
   assign LD_READY = r_ld_ready;
   assign JAM_RST  = r_jam_rst;
   assign DONE     = r_done;
   assign PASS     = r_pass;
   assign TIMEOUT  = r_timeout;
   assign CYCLES   = r_cycles;

endmodule

// File: tb/tb_jam_cost_table.sv
// Bench for jam_cost_table: randomized loads and lookups compared every cycle against a behavioural model.
module tb_jam_cost_table;
   localparam int TO = 16;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        LD_VALID = 1'b0;
   logic [6:0]  LD_DATA = '0;
   logic        LD_READY, JAM_RST;
   logic [2:0]  W = '0, J = '0;
   logic [6:0]  Cost;
   logic        Valid = 1'b0;
   logic [9:0]  MinCost = '0;
   logic [3:0]  MatchCount = '0;
   logic [9:0]  EXP_MIN = '0;
   logic [3:0]  EXP_CNT = '0;
   logic        DONE, PASS, TIMEOUT;
   logic [19:0] CYCLES;

   int checks = 0;
   int errors = 0;

   // Behavioural model: edges since release, entries loaded, serve-cycle count, outcome flags.
   int m_edges, m_loaded, m_cyc;
   bit m_done, m_pass, m_to;
   int m_tab [64];

   jam_cost_table #(.TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST_N(RST_N), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
      .LD_READY(LD_READY), .JAM_RST(JAM_RST), .W(W), .J(J), .Cost(Cost),
      .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
      .EXP_MIN(EXP_MIN), .EXP_CNT(EXP_CNT), .DONE(DONE), .PASS(PASS),
      .TIMEOUT(TIMEOUT), .CYCLES(CYCLES)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_edges = 0; m_loaded = 0; m_cyc = 0;
         m_done = 0; m_pass = 0; m_to = 0;
         for (int i = 0; i < 64; i++) m_tab[i] = 0;
      end else begin
         bit rdy;
         rdy = (m_edges >= 2) && (m_loaded < 64);
         if (m_loaded == 64) begin
            if (!m_done) begin
               if (Valid) begin
                  m_done = 1;
                  m_pass = (MinCost == EXP_MIN) && (MatchCount == EXP_CNT);
               end else if (m_cyc == TO) begin
                  m_to = 1; m_done = 1; m_pass = 0;
               end else if (m_cyc < 1048575) begin
                  m_cyc++;
               end
            end
         end else if (rdy && LD_VALID) begin
            m_tab[m_loaded] = int'(LD_DATA);
            m_loaded++;
         end
         if (m_edges < 2) m_edges++;
      end
   end

   always @(negedge CLK) begin
      chk("ld_ready", int'(LD_READY), int'((m_edges >= 2) && (m_loaded < 64)));
      chk("jam_rst", int'(JAM_RST), int'(m_loaded < 64));
      chk("done", int'(DONE), int'(m_done));
      chk("timeout", int'(TIMEOUT), int'(m_to));
      chk("pass", int'(PASS), m_done ? int'(m_pass) : 0);
      if (m_loaded == 64 && (!m_done || m_to)) chk("cycles", int'(CYCLES), m_cyc);
      if (m_loaded == 64 || m_loaded == 0) chk("cost", int'(Cost), m_tab[{W, J}]);
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      LD_VALID = 1'b1;
      repeat (3) step();
      chk("rst_ld_ready", int'(LD_READY), 0);
      chk("rst_jam_rst", int'(JAM_RST), 1);
      chk("rst_cost", int'(Cost), 0);
      chk("rst_done", int'(DONE), 0);
      chk("rst_pass", int'(PASS), 0);
      chk("rst_timeout", int'(TIMEOUT), 0);
      LD_VALID = 1'b0;
      RST_N = 1'b1;
      step();
      chk("ready_edge1", int'(LD_READY), 0);
      step();
      chk("ready_edge2", int'(LD_READY), 1);
   endtask

   // mode 0: (k%100)+1, mode 1: k, mode 2: random. gapmode 0: every 3rd cycle idle, 1: random idles.
   task automatic load(input int n, input int mode, input int gapmode);
      int k = 0;
      int c = 0;
      bit rdy;
      while (k < n && c < 2000) begin
         rdy = LD_READY;
         LD_VALID = (gapmode == 0) ? (c % 3 != 2) : ($urandom_range(0, 2) != 0);
         LD_DATA = (mode == 0) ? 7'((k % 100) + 1) : (mode == 1) ? 7'(k) : 7'($urandom);
         @(posedge CLK);
         if (rdy && LD_VALID) k++;
         c++;
         #2;
      end
      LD_VALID = 1'b0;
      if (k < n) chk("load_bound", k, n);
   endtask

   task automatic serve_idle(input int n);
      repeat (n) begin
         W = 3'($urandom);
         J = 3'($urandom);
         step();
      end
   endtask

   task automatic pulse_valid(input int mc, input int cnt);
      MinCost = 10'(mc);
      MatchCount = 4'(cnt);
      Valid = 1'b1;
      step();
      Valid = 1'b0;
   endtask

   task automatic lookup(input string name, input int w, input int j, input int exp);
      W = 3'(w);
      J = 3'(j);
      #1;
      chk(name, int'(Cost), exp);
   endtask

   initial begin
      int b;
      EXP_MIN = 10'd252;
      EXP_CNT = 4'd2;

      // Reset, load with gaps, fixed lookups, pass result.
      do_reset();
      load(64, 0, 0);
      chk("ld_ready_fall", int'(LD_READY), 0);
      chk("jam_rst_fall", int'(JAM_RST), 0);
      lookup("cost_w3j5", 3, 5, 30);
      lookup("cost_w7j7", 7, 7, 64);
      lookup("cost_w0j0", 0, 0, 1);
      serve_idle($urandom_range(1, 8));
      pulse_valid(252, 2);
      chk("pass_done", int'(DONE), 1);
      chk("pass_pass", int'(PASS), 1);
      chk("pass_timeout", int'(TIMEOUT), 0);
      serve_idle(3);
      pulse_valid(0, 2);
      serve_idle(2);
      chk("pass_sticky", int'(PASS), 1);

      // Wrong match count.
      do_reset();
      load(64, 2, 1);
      serve_idle($urandom_range(0, 10));
      pulse_valid(252, 3);
      chk("fail_done", int'(DONE), 1);
      chk("fail_pass", int'(PASS), 0);

      // Watchdog.
      do_reset();
      load(64, 2, 1);
      b = 0;
      while (!DONE && b < 100) begin
         serve_idle(1);
         b++;
      end
      chk("to_seen", int'(DONE), 1);
      chk("to_timeout", int'(TIMEOUT), 1);
      chk("to_pass", int'(PASS), 0);
      chk("to_cycles", int'(CYCLES), 16);
      serve_idle(5);
      pulse_valid(252, 2);
      chk("to_cycles_frozen", int'(CYCLES), 16);
      chk("to_pass_hold", int'(PASS), 0);

      // Valid in the same cycle the watchdog would fire.
      do_reset();
      load(64, 2, 1);
      b = 0;
      while (CYCLES != 20'd16 && b < 100) begin
         serve_idle(1);
         b++;
      end
      chk("sim_reached16", int'(CYCLES), 16);
      pulse_valid(252, 2);
      chk("sim_done", int'(DONE), 1);
      chk("sim_pass", int'(PASS), 1);
      chk("sim_timeout", int'(TIMEOUT), 0);

      // Reset in the middle of a load clears the table.
      do_reset();
      load(10, 2, 1);
      RST_N = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) lookup("midrst_cost", $urandom_range(0, 1), $urandom_range(0, 7), 0);
      do_reset();
      load(64, 1, 0);
      lookup("reload_w1j2", 1, 2, 10);
      serve_idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual running required finished");
      $fatal(1);
   end
endmodule
